// File: rtl/uart_word_tx.sv
// rtl/uart_word_tx.sv - word FIFO and byte serializer feeding uart_tx start_n/data
`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module uart_word_tx #(
    parameter int WORD_WIDTH = `WORD_WIDTH,
    parameter int FIFO_DEPTH = 4,
    localparam int BYTES = WORD_WIDTH / 8,
    localparam int PTR_W = $clog2(FIFO_DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    input  logic                  tx_ready,
    output logic                  tx_start_n,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      fifo_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic                  tx_start_n_q, tx_start_n_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic push;
    logic pop;

    // Ready is derived from the registered count, so a pop at full frees the slot only next cycle.
    assign word_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push       = word_valid && word_ready;
    assign busy       = (state_q != ST_IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign tx_start_n = tx_start_n_q;
    assign tx_data    = tx_data_q;

    // Next-state logic for the byte sequencer and FIFO pointers.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        tx_start_n_d = tx_start_n_q;
        tx_data_d    = tx_data_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        pop          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_start_n_d = 1'b1;
                if ((count_q != '0) && tx_ready) begin
                    pop          = 1'b1;
                    shift_d      = mem_q[rd_ptr_q];
                    tx_data_d    = mem_q[rd_ptr_q][7:0];
                    byte_idx_d   = '0;
                    tx_start_n_d = 1'b0;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                // Keep requesting until the transmitter shows it has taken the byte.
                if (!tx_ready) begin
                    tx_start_n_d = 1'b1;
                    state_d      = ST_WAIT_DONE;
                end else begin
                    tx_start_n_d = 1'b0;
                end
            end
            ST_WAIT_DONE: begin
                tx_start_n_d = 1'b1;
                if (tx_ready) begin
                    if (byte_idx_q == IDX_W'(BYTES - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        shift_d      = shift_q >> 8;
                        tx_data_d    = shift_d[7:0];
                        byte_idx_d   = byte_idx_q + 1'b1;
                        tx_start_n_d = 1'b0;
                        state_d      = ST_START;
                    end
                end
            end
            default: begin
                tx_start_n_d = 1'b1;
                state_d      = ST_IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Sequencer, outputs and FIFO bookkeeping; reset discards everything, including a word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            tx_start_n_q <= 1'b1;
            tx_data_q    <= 8'h00;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            tx_start_n_q <= tx_start_n_d;
            tx_data_q    <= tx_data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word_in;
        end
    end

endmodule
